// File: rtl/host_ctl_if.sv
// Host-side signal bundle for host_ctl: preload stream, data-memory port,
// result stream, core hold/done and run status.
interface host_ctl_if;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;

    logic          start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          cpu_reset;
    logic          cpu_done;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_di;
    logic [DW-1:0] dm_dout;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          busy;
    logic          timeout;
    logic [CW-1:0] cycles;
    logic          fin;

    // Host / environment side: drives requests, memory read data and the core done flag
    modport master (
        output start, ld_valid, ld_data, cpu_done, dm_dout, rd_ready,
        input  ld_ready, cpu_reset, dm_we, dm_addr, dm_di, rd_valid, rd_data,
               busy, timeout, cycles, fin
    );

    // Controller side
    modport slave (
        input  start, ld_valid, ld_data, cpu_done, dm_dout, rd_ready,
        output ld_ready, cpu_reset, dm_we, dm_addr, dm_di, rd_valid, rd_data,
               busy, timeout, cycles, fin
    );
endinterface

// File: rtl/host_ctl.sv
// Host sequencer for a small processor: preloads data memory, releases the core
// until it halts or times out, then streams result bytes back to the host.
module host_ctl #(
    parameter int unsigned N_LOAD    = 8,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned N_DUMP    = 4,
    parameter int unsigned DUMP_BASE = 8,
    parameter int unsigned MAX_CYC   = 4096
) (
    input  logic      clk,
    input  logic      reset,
    host_ctl_if.slave bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [AW-1:0] LOAD_ADDR0 = AW'(LOAD_BASE);
    localparam logic [AW-1:0] DUMP_ADDR0 = AW'(DUMP_BASE);
    localparam logic [AW-1:0] LOAD_LAST  = AW'(N_LOAD - 1);
    localparam logic [AW-1:0] DUMP_LAST  = AW'(N_DUMP - 1);
    localparam logic [CW-1:0] CYC_LIMIT  = CW'(MAX_CYC);
    localparam logic          HAS_LOAD   = (N_LOAD != 0);

    logic [2:0]    state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [AW-1:0] addr, addr_nx;
    logic [CW-1:0] cycles, cycles_nx;
    logic          timeout, timeout_nx;
    logic          ld_ready_q, cpu_reset_q, rd_valid_q, busy_q, fin_q;
    logic          ld_acc;
    logic          rd_acc;
    logic          run_first;

    assign ld_acc    = ld_ready_q & bus.ld_valid;
    assign rd_acc    = rd_valid_q & bus.rd_ready;
    // cycles is loaded with 1 on RUN entry, so a value of 1 marks the first RUN cycle
    assign run_first = (cycles == CW'(1));

    // Next-state, index, address and run-statistics logic
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        addr_nx    = addr;
        cycles_nx  = cycles;
        timeout_nx = timeout;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    cycles_nx  = '0;
                    timeout_nx = 1'b0;
                    idx_nx     = '0;
                    if (HAS_LOAD) begin
                        state_nx = S_LOAD;
                        addr_nx  = LOAD_ADDR0;
                    end else begin
                        state_nx  = S_RUN;
                        cycles_nx = CW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (ld_acc) begin
                    idx_nx  = idx + AW'(1);
                    addr_nx = addr + AW'(1);
                    if (idx == LOAD_LAST) begin
                        state_nx  = S_RUN;
                        cycles_nx = CW'(1);
                    end
                end
            end
            S_RUN: begin
                // done takes priority over the limit; the core's done is stale in cycle 1
                if (bus.cpu_done && !run_first) begin
                    state_nx = S_DUMP;
                    idx_nx   = '0;
                    addr_nx  = DUMP_ADDR0;
                end else if (cycles >= CYC_LIMIT) begin
                    state_nx   = S_DUMP;
                    timeout_nx = 1'b1;
                    idx_nx     = '0;
                    addr_nx    = DUMP_ADDR0;
                end else begin
                    cycles_nx = cycles + CW'(1);
                end
            end
            S_DUMP: begin
                if (rd_acc) begin
                    if (idx == DUMP_LAST) begin
                        state_nx = S_FIN;
                    end else begin
                        idx_nx  = idx + AW'(1);
                        addr_nx = addr + AW'(1);
                    end
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register plus state-decoded control flops, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            addr        <= '0;
            cycles      <= '0;
            timeout     <= 1'b0;
            ld_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            addr        <= addr_nx;
            cycles      <= cycles_nx;
            timeout     <= timeout_nx;
            ld_ready_q  <= (state_nx == S_LOAD);
            cpu_reset_q <= (state_nx != S_RUN);
            rd_valid_q  <= (state_nx == S_DUMP);
            busy_q      <= (state_nx != S_IDLE);
            fin_q       <= (state_nx == S_FIN);
        end
    end

    // Write strobe/data and read data pass straight through the accepted handshake
    assign bus.dm_we     = ld_acc;
    assign bus.dm_di     = ld_acc ? bus.ld_data : DW'(0);
    assign bus.dm_addr   = addr;
    assign bus.rd_data   = rd_valid_q ? bus.dm_dout : DW'(0);
    assign bus.ld_ready  = ld_ready_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.fin       = fin_q;
    assign bus.timeout   = timeout;
    assign bus.cycles    = cycles;
endmodule

// File: tb/tb_host_ctl.sv
// Directed bench for host_ctl: a default instance and a small wrap/timeout instance,
// each with a behavioural data memory.
module tb_host_ctl;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    int   n_tests;
    int   n_fail;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    host_ctl_if b0 ();
    host_ctl_if b1 ();

    host_ctl u0 (.clk(clk), .reset(reset), .bus(b0));
    host_ctl #(.N_LOAD(4), .LOAD_BASE(254), .N_DUMP(2), .DUMP_BASE(255), .MAX_CYC(16))
        u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Memories: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= init_val(8'(i));
                mem1[i] <= init_val(8'(i));
            end
        end else begin
            if (b0.dm_we) mem0[b0.dm_addr] <= b0.dm_di;
            if (b1.dm_we) mem1[b1.dm_addr] <= b1.dm_di;
        end
    end
    assign b0.dm_dout = mem0[b0.dm_addr];
    assign b1.dm_dout = mem1[b1.dm_addr];

    task automatic test_reset;
        logic [6:0] obs;
        logic [31:0] ov;
        #1;
        obs = {b0.busy, b0.cpu_reset, b0.ld_ready, b0.rd_valid, b0.dm_we, b0.fin, b0.timeout};
        n_tests++; if (obs !== 7'b0100000) begin n_fail++; $display("FAIL reset_ctl0: got %b want 0100000", obs); end
        ov = {b0.dm_addr, b0.dm_di, b0.cycles};
        n_tests++; if (ov !== 32'h0) begin n_fail++; $display("FAIL reset_data0: got %h want 00000000", ov); end
        obs = {b1.busy, b1.cpu_reset, b1.ld_ready, b1.rd_valid, b1.dm_we, b1.fin, b1.timeout};
        n_tests++; if (obs !== 7'b0100000) begin n_fail++; $display("FAIL reset_ctl1: got %b want 0100000", obs); end
        ov = {b1.dm_addr, b1.dm_di, b1.cycles};
        n_tests++; if (ov !== 32'h0) begin n_fail++; $display("FAIL reset_data1: got %h want 00000000", ov); end
    endtask

    task automatic test_load;
        logic [3:0]  obs;
        logic [15:0] ad;
        logic [7:0]  v;
        b0.ld_valid = 1'b1; b0.ld_data = 8'h11; #1;
        obs = {b0.ld_ready, b0.dm_we, b0.busy, b0.cpu_reset};
        n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL idle_ignores_ld: got %b want 0001", obs); end
        b0.start = 1'b1;
        @(negedge clk); b0.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 8'((i + 1) * 17);
            b0.ld_data = v; #1;
            obs = {b0.dm_we, b0.ld_ready, b0.cpu_reset, b0.busy};
            n_tests++; if (obs !== 4'b1111) begin n_fail++; $display("FAIL load_ctl[%0d]: got %b want 1111", i, obs); end
            ad = {b0.dm_addr, b0.dm_di};
            n_tests++; if (ad !== {8'(i), v}) begin n_fail++; $display("FAIL load_wr[%0d]: got %h want %h", i, ad, {8'(i), v}); end
            @(negedge clk);
        end
        #1;
        obs = {b0.dm_we, b0.ld_ready, b0.cpu_reset, b0.busy};
        n_tests++; if (obs !== 4'b0001) begin n_fail++; $display("FAIL run_entry_ctl: got %b want 0001", obs); end
        b0.ld_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 8'((i + 1) * 17);
            n_tests++; if (mem0[i] !== v) begin n_fail++; $display("FAIL load_mem[%0d]: got %h want %h", i, mem0[i], v); end
        end
    endtask

    task automatic test_run_done;
        logic [3:0] obs;
        for (int c = 1; c <= 20; c++) begin
            b0.cpu_done = (c == 1 || c == 20); #1;
            n_tests++; if (b0.cycles !== 16'(c)) begin n_fail++; $display("FAIL run_cycles[%0d]: got %0d want %0d", c, b0.cycles, c); end
            obs = {1'b0, b0.cpu_reset, b0.busy, b0.rd_valid};
            n_tests++; if (obs !== 4'b0010) begin n_fail++; $display("FAIL run_ctl[%0d]: got %b want 0010", c, obs); end
            @(negedge clk);
        end
        b0.cpu_done = 1'b0; #1;
        obs = {b0.cpu_reset, b0.rd_valid, b0.busy, b0.timeout};
        n_tests++; if (obs !== 4'b1110) begin n_fail++; $display("FAIL done_ctl: got %b want 1110", obs); end
        n_tests++; if (b0.cycles !== 16'd20) begin n_fail++; $display("FAIL done_cycles: got %0d want 20", b0.cycles); end
    endtask

    task automatic test_dump;
        logic [16:0] obs;
        logic [3:0]  c4;
        logic [2:0]  c3;
        b0.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            obs = {b0.rd_valid, b0.dm_addr, b0.rd_data};
            n_tests++; if (obs !== {1'b1, 8'(8 + k), init_val(8'(8 + k))}) begin
                n_fail++; $display("FAIL dump[%0d]: got %h want %h", k, obs, {1'b1, 8'(8 + k), init_val(8'(8 + k))});
            end
            @(negedge clk);
        end
        #1;
        c4 = {b0.fin, b0.busy, b0.rd_valid, b0.cpu_reset};
        n_tests++; if (c4 !== 4'b1101) begin n_fail++; $display("FAIL fin_state: got %b want 1101", c4); end
        @(negedge clk); #1;
        c3 = {b0.fin, b0.busy, b0.cpu_reset};
        n_tests++; if (c3 !== 3'b001) begin n_fail++; $display("FAIL back_idle: got %b want 001", c3); end
        n_tests++; if ({b0.timeout, b0.cycles} !== {1'b0, 16'd20}) begin
            n_fail++; $display("FAIL hold_stats: got %b/%0d want 0/20", b0.timeout, b0.cycles);
        end
        b0.rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [9:0]  o10;
        logic [16:0] obs;
        logic [7:0]  ea [7];
        logic        rdy [7];
        ea  = '{8'd8, 8'd9, 8'd9, 8'd9, 8'd9, 8'd10, 8'd11};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        b0.start = 1'b1; b0.ld_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (b0.cycles !== 16'd0) begin n_fail++; $display("FAIL start_clears_cycles: got %0d want 0", b0.cycles); end
        o10 = {b0.ld_ready, b0.dm_we, b0.dm_addr};
        n_tests++; if (o10 !== 10'b10_0000_0000) begin n_fail++; $display("FAIL load_stall: got %b want 1000000000", o10); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b0.ld_valid = 1'b1; b0.ld_data = 8'hF0 + 8'(i); #1;
            obs = {b0.dm_we, b0.dm_addr, b0.dm_di};
            n_tests++; if (obs !== {1'b1, 8'(i), 8'hF0 + 8'(i)}) begin
                n_fail++; $display("FAIL b2b_load[%0d]: got %h want %h", i, obs, {1'b1, 8'(i), 8'hF0 + 8'(i)});
            end
            @(negedge clk);
        end
        b0.ld_valid = 1'b0; b0.cpu_done = 1'b1; #1;
        n_tests++; if (b0.cycles !== 16'd1) begin n_fail++; $display("FAIL b2b_cyc1: got %0d want 1", b0.cycles); end
        @(negedge clk); #1;
        n_tests++; if ({b0.cpu_reset, b0.cycles} !== {1'b0, 16'd2}) begin
            n_fail++; $display("FAIL b2b_cyc2: got %b/%0d want 0/2", b0.cpu_reset, b0.cycles);
        end
        @(negedge clk); b0.start = 1'b0; b0.cpu_done = 1'b0; #1;
        n_tests++; if ({b0.rd_valid, b0.cycles} !== {1'b1, 16'd2}) begin
            n_fail++; $display("FAIL b2b_dump_entry: got %b/%0d want 1/2", b0.rd_valid, b0.cycles);
        end
        n_tests++; if (mem0[3] !== 8'hF3) begin n_fail++; $display("FAIL b2b_mem3: got %h want f3", mem0[3]); end
        for (int k = 0; k < 7; k++) begin
            b0.rd_ready = rdy[k]; #1;
            obs = {b0.rd_valid, b0.dm_addr, b0.rd_data};
            n_tests++; if (obs !== {1'b1, ea[k], init_val(ea[k])}) begin
                n_fail++; $display("FAIL stall_dump[%0d]: got %h want %h", k, obs, {1'b1, ea[k], init_val(ea[k])});
            end
            @(negedge clk);
        end
        b0.rd_ready = 1'b0; #1;
        n_tests++; if (b0.fin !== 1'b1) begin n_fail++; $display("FAIL b2b_fin: got %b want 1", b0.fin); end
        @(negedge clk); @(negedge clk); #1;
        n_tests++; if ({b0.busy, b0.fin} !== 2'b00) begin n_fail++; $display("FAIL b2b_stay_idle: got %b want 00", {b0.busy, b0.fin}); end
    endtask

    task automatic test_timeout;
        logic [16:0] obs;
        logic [2:0]  c3;
        b1.start = 1'b1; b1.ld_valid = 1'b1;
        @(negedge clk); b1.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b1.ld_data = 8'hC1 + 8'(i); #1;
            obs = {b1.dm_we, b1.dm_addr, b1.dm_di};
            n_tests++; if (obs !== {1'b1, 8'(254 + i), 8'hC1 + 8'(i)}) begin
                n_fail++; $display("FAIL wrap_load[%0d]: got %h want %h", i, obs, {1'b1, 8'(254 + i), 8'hC1 + 8'(i)});
            end
            @(negedge clk);
        end
        b1.ld_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            n_tests++; if ({b1.cpu_reset, b1.cycles} !== {1'b0, 16'(c)}) begin
                n_fail++; $display("FAIL to_run[%0d]: got %b/%0d want 0/%0d", c, b1.cpu_reset, b1.cycles, c);
            end
            @(negedge clk);
        end
        #1;
        c3 = {b1.timeout, b1.rd_valid, b1.cpu_reset};
        n_tests++; if (c3 !== 3'b111) begin n_fail++; $display("FAIL to_flag: got %b want 111", c3); end
        n_tests++; if (b1.cycles !== 16'd16) begin n_fail++; $display("FAIL to_cycles: got %0d want 16", b1.cycles); end
        b1.rd_ready = 1'b1;
        n_tests++; if ({b1.dm_addr, b1.rd_data} !== 16'hFF_C2) begin
            n_fail++; $display("FAIL wrap_dump0: got %h want ffc2", {b1.dm_addr, b1.rd_data});
        end
        @(negedge clk); #1;
        n_tests++; if ({b1.dm_addr, b1.rd_data} !== 16'h00_C3) begin
            n_fail++; $display("FAIL wrap_dump1: got %h want 00c3", {b1.dm_addr, b1.rd_data});
        end
        n_tests++; if ({mem1[254], mem1[1]} !== 16'hC1_C4) begin
            n_fail++; $display("FAIL wrap_mem: got %h want c1c4", {mem1[254], mem1[1]});
        end
        @(negedge clk); #1;
        n_tests++; if (b1.fin !== 1'b1) begin n_fail++; $display("FAIL to_fin: got %b want 1", b1.fin); end
        b1.rd_ready = 1'b0;
        @(negedge clk); #1;
        n_tests++; if ({b1.busy, b1.timeout, b1.cycles} !== {1'b0, 1'b1, 16'd16}) begin
            n_fail++; $display("FAIL to_sticky: got %b/%b/%0d want 0/1/16", b1.busy, b1.timeout, b1.cycles);
        end
    endtask

    task automatic test_limit_tie;
        b1.start = 1'b1; b1.ld_valid = 1'b1; b1.ld_data = 8'h5C;
        @(negedge clk); b1.start = 1'b0; #1;
        n_tests++; if ({b1.timeout, b1.cycles} !== 17'd0) begin
            n_fail++; $display("FAIL tie_clear: got %b/%0d want 0/0", b1.timeout, b1.cycles);
        end
        repeat (4) @(negedge clk);
        b1.ld_valid = 1'b0;
        repeat (15) @(negedge clk);
        b1.cpu_done = 1'b1; #1;
        n_tests++; if (b1.cycles !== 16'd16) begin n_fail++; $display("FAIL tie_cyc: got %0d want 16", b1.cycles); end
        @(negedge clk); b1.cpu_done = 1'b0; #1;
        n_tests++; if ({b1.timeout, b1.rd_valid, b1.cycles} !== {1'b0, 1'b1, 16'd16}) begin
            n_fail++; $display("FAIL tie_result: got %b/%b/%0d want 0/1/16", b1.timeout, b1.rd_valid, b1.cycles);
        end
        b1.rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        b1.rd_ready = 1'b0; #1;
        n_tests++; if ({b1.busy, b1.timeout} !== 2'b00) begin
            n_fail++; $display("FAIL tie_idle: got %b want 00", {b1.busy, b1.timeout});
        end
    endtask

    task automatic test_reset_mid_run;
        logic [5:0]  c6;
        logic [16:0] obs;
        b0.start = 1'b1; b0.ld_valid = 1'b1; b0.ld_data = 8'h99;
        @(negedge clk); b0.start = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0; #1;
        n_tests++; if ({b0.dm_we, b0.ld_ready, b0.busy} !== 3'b000) begin
            n_fail++; $display("FAIL load_abort: got %b want 000", {b0.dm_we, b0.ld_ready, b0.busy});
        end
        @(negedge clk); reset = 1'b1; b0.ld_valid = 1'b0; #1;
        n_tests++; if ({mem0[2], mem0[1]} !== 16'hF2_99) begin
            n_fail++; $display("FAIL abort_no_write: got %h want f299", {mem0[2], mem0[1]});
        end
        b0.start = 1'b1; b0.ld_valid = 1'b1;
        @(negedge clk); b0.start = 1'b0;
        repeat (8) @(negedge clk);
        b0.ld_valid = 1'b0;
        repeat (4) @(negedge clk); #1;
        n_tests++; if (b0.cycles !== 16'd5) begin n_fail++; $display("FAIL pre_reset_cyc: got %0d want 5", b0.cycles); end
        reset = 1'b0; #1;
        c6 = {b0.busy, b0.cpu_reset, b0.rd_valid, b0.ld_ready, b0.fin, b0.timeout};
        n_tests++; if (c6 !== 6'b010000) begin n_fail++; $display("FAIL run_abort_ctl: got %b want 010000", c6); end
        n_tests++; if ({b0.cycles, b0.dm_addr} !== 24'd0) begin
            n_fail++; $display("FAIL run_abort_data: got %0d/%h want 0/00", b0.cycles, b0.dm_addr);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        n_tests++; if ({b0.busy, b0.cpu_reset} !== 2'b01) begin
            n_fail++; $display("FAIL resume_idle: got %b want 01", {b0.busy, b0.cpu_reset});
        end
        b0.start = 1'b1; b0.ld_valid = 1'b1; b0.ld_data = 8'h42;
        @(negedge clk); b0.start = 1'b0; #1;
        n_tests++; if ({b0.ld_ready, b0.cycles} !== {1'b1, 16'd0}) begin
            n_fail++; $display("FAIL rerun_load: got %b/%0d want 1/0", b0.ld_ready, b0.cycles);
        end
        repeat (8) @(negedge clk);
        b0.ld_valid = 1'b0; b0.cpu_done = 1'b1; #1;
        n_tests++; if ({b0.cpu_reset, b0.cycles} !== {1'b0, 16'd1}) begin
            n_fail++; $display("FAIL rerun_run: got %b/%0d want 0/1", b0.cpu_reset, b0.cycles);
        end
        @(negedge clk); @(negedge clk);
        b0.cpu_done = 1'b0; b0.rd_ready = 1'b1; #1;
        obs = {b0.rd_valid, b0.dm_addr, b0.rd_data};
        n_tests++; if (obs !== {1'b1, 8'd8, init_val(8'd8)} || b0.cycles !== 16'd2) begin
            n_fail++; $display("FAIL rerun_dump: got %h/%0d want %h/2", obs, b0.cycles, {1'b1, 8'd8, init_val(8'd8)});
        end
        repeat (4) @(negedge clk); #1;
        n_tests++; if (b0.fin !== 1'b1) begin n_fail++; $display("FAIL rerun_fin: got %b want 1", b0.fin); end
        @(negedge clk); b0.rd_ready = 1'b0; #1;
        n_tests++; if ({b0.busy, mem0[7]} !== {1'b0, 8'h42}) begin
            n_fail++; $display("FAIL rerun_end: got %b/%h want 0/42", b0.busy, mem0[7]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b0; mem_clr = 1'b1;
        b0.start = 1'b0; b0.ld_valid = 1'b1; b0.ld_data = 8'hAA; b0.cpu_done = 1'b0; b0.rd_ready = 1'b0;
        b1.start = 1'b0; b1.ld_valid = 1'b0; b1.ld_data = 8'h00; b1.cpu_done = 1'b0; b1.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        mem_clr = 1'b0; reset = 1'b1; b0.ld_valid = 1'b0;
        @(negedge clk);
        test_load();
        test_run_done();
        test_dump();
        test_back_to_back();
        test_timeout();
        test_limit_tie();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/host_ctl.md
HOST_CTL -- requirements
Module: host_ctl

Interface
REQ-001 Parameter N_LOAD, default 8: bytes preloaded into data memory per run (0..255).
REQ-002 Parameter LOAD_BASE, default 0: first data-memory address written during preload.
REQ-003 Parameter N_DUMP, default 4: result bytes read back per run (1..255).
REQ-004 Parameter DUMP_BASE, default 8: first data-memory address read during dump.
REQ-005 Parameter MAX_CYC, default 4096: RUN-cycle limit before timeout (1..65535).
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  host request to begin a run; sampled in IDLE only.
REQ-009 ld_valid  in  1  preload byte valid.
REQ-010 ld_data  in  8  preload byte.
REQ-011 ld_ready  out  1  host_ctl accepts ld_data this cycle.
REQ-012 cpu_reset  out  1  active-high hold to processor core (PC reset).
REQ-013 cpu_done  in  1  processor done flag (halt instruction decoded).
REQ-014 dm_we  out  1  data-memory write enable, host side.
REQ-015 dm_addr  out  8  data-memory address, host side.
REQ-016 dm_di  out  8  data-memory write data.
REQ-017 dm_dout  in  8  data-memory read data, combinational from dm_addr.
REQ-018 rd_valid  out  1  result byte valid.
REQ-019 rd_data  out  8  result byte.
REQ-020 rd_ready  in  1  host accepts rd_data.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 timeout  out  1  sticky; set when a run hits MAX_CYC.
REQ-023 cycles  out  16  RUN cycles of last run.
REQ-024 fin  out  1  one-cycle pulse at end of each run.

Function
REQ-025 FSM states IDLE, LOAD, RUN, DUMP, FIN; one-hot or binary is implementer choice.
REQ-026 IDLE: cpu_reset=1, ld_ready=0, rd_valid=0, dm_we=0; start=1 -> LOAD (N_LOAD>0) or RUN (N_LOAD=0); clear timeout and cycles on that transition.
REQ-027 LOAD: ld_ready=1, cpu_reset=1; ld_valid&ld_ready -> dm_we=1, dm_addr=LOAD_BASE+idx, dm_di=ld_data same cycle, idx+1.
REQ-028 LOAD: after byte N_LOAD-1 accepted -> RUN next cycle; ld_valid low stalls with no write.
REQ-029 Address arithmetic SHALL be 8-bit modulo 256 (LOAD_BASE+idx and DUMP_BASE+idx wrap).
REQ-030 RUN: cpu_reset=0, dm_we=0, ld_ready=0; cycles increments each RUN cycle, starting at 1 in first RUN cycle.
REQ-031 RUN: cpu_done ignored in first RUN cycle (PC still 0); from second RUN cycle, cpu_done=1 -> DUMP.
REQ-032 RUN: cycles reaching MAX_CYC without done -> timeout=1, DUMP; done and limit in same cycle -> DUMP with timeout=0.
REQ-033 DUMP: cpu_reset=1, rd_valid=1, dm_addr=DUMP_BASE+idx, rd_data=dm_dout; idx advances only on rd_valid&rd_ready.
REQ-034 DUMP: dm_addr and rd_data SHALL stay stable while rd_valid&!rd_ready.
REQ-035 DUMP: after byte N_DUMP-1 accepted -> FIN; FIN asserts fin=1 one cycle, then IDLE.
REQ-036 start outside IDLE ignored; ld_valid outside LOAD ignored, no write.
REQ-037 idx cleared on entry to LOAD and to DUMP.
REQ-038 cycles and timeout hold values from end of RUN until next start.

Reset
REQ-039 reset=0 SHALL immediately force IDLE, idx=0, cycles=0, timeout=0, fin=0, dm_we=0, ld_ready=0, rd_valid=0, busy=0, cpu_reset=1, dm_addr=0, dm_di=0.
REQ-040 reset asserted mid-LOAD/RUN/DUMP SHALL abort with no further dm write; deassertion resumes in IDLE on next edge.

Verification
REQ-041 Load 8 bytes 0x11..0x88, continuous ld_valid -> dm writes addr 0..7 in 8 consecutive cycles, RUN on 9th cycle.
REQ-042 cpu_done high at RUN cycle 20, rd_ready=1 -> cycles=20, timeout=0, 4 bytes from addr 8..11 on consecutive cycles, fin pulse, IDLE.
REQ-043 cpu_done held low, MAX_CYC=16 -> timeout=1, cycles=16, dump proceeds, fin pulses.
REQ-044 rd_ready low 3 cycles on byte 1 -> dm_addr=9 and rd_data unchanged for 3 cycles, no skipped/duplicated byte.
REQ-045 LOAD_BASE=254, N_LOAD=4 -> writes to 254,255,0,1.
REQ-046 reset pulsed low mid-RUN at cycle 5 -> cpu_reset=1 same cycle, busy=0, cycles=0; start afterwards runs normally.
